vga_rom_arbiter: RTL and testbench
==================================

// Module: vga_rom_arbiter
// PURPOSE
// - Shares one synchronous single-port image ROM (1-cycle registered read) between two requesters.
// - Pixel port: VGA scan fetch, absolute priority, fixed latency, no back-pressure.
// - Aux port: sprite/overlay/debug readback, req/gnt handshake, served in cycles without a pixel request.
// - Sits between the VGA timing/address generator and the image ROM instance; owns the ROM address bus.
// PARAMETERS
// - DATA_WIDTH   8    ROM word width
// - ADDR_WIDTH   8    ROM address width
// - STARVE_LIMIT 1024 consecutive aux wait cycles before aux_starve asserts (>=1)
// - CNT_WIDTH    16   width of aux wait counter; must hold STARVE_LIMIT
// PORTS
// - clk        in  1          system clock, all logic on rising edge
// - rst_n      in  1          asynchronous active-low reset
// - pix_req    in  1          pixel fetch request this cycle
// - pix_addr   in  ADDR_WIDTH pixel fetch address, sampled with pix_req
// - pix_rvalid out 1          pixel data valid
// - pix_rdata  out DATA_WIDTH pixel data
// - aux_req    in  1          aux request; held with aux_addr stable until aux_gnt
// - aux_addr   in  ADDR_WIDTH aux address
// - aux_gnt    out 1          combinational grant; request consumed this cycle
// - aux_rvalid out 1          aux data valid
// - aux_rdata  out DATA_WIDTH aux data
// - aux_starve out 1          aux waited >= STARVE_LIMIT cycles (sticky until next aux_gnt)
// - rom_addr   out ADDR_WIDTH registered ROM address
// - rom_q      in  DATA_WIDTH ROM read data (valid 1 cycle after rom_addr)
// BEHAVIOUR
// - Reset: rom_addr=0, pix_rvalid=0, aux_rvalid=0, pix_rdata=0, aux_rdata=0, aux_starve=0, wait cnt=0, tag pipe empty.
// - Arbitration per cycle: pix_req wins; aux_gnt = aux_req & ~pix_req. At most one grant per cycle.
// - Granted address registered into rom_addr at edge t+1; ROM q valid at t+2.
// - Owner tag {valid, is_aux} shifts through a 2-stage pipe alongside address; at t+2 edge the matching
//   *_rvalid asserts for one cycle and *_rdata captures rom_q. Latency req->rvalid = 2 cycles (base).
// - No grant: rom_addr holds value, tag valid=0, no rvalid. *_rdata holds last value when rvalid=0.
// - Back-to-back: one result per cycle, order preserved; pix and aux rvalid never assert in the same cycle.
// - Wait counter: increments (saturating at STARVE_LIMIT) each cycle aux_req & ~aux_gnt; clears on aux_gnt
//   or aux_req=0. aux_starve sets when counter reaches STARVE_LIMIT, clears on aux_gnt.
// - aux_req dropped without grant: legal, no side effect except counter clear.
// - Reset mid-operation: tag pipe flushed; no rvalid for requests issued before reset.
// CONFIGURATION
// - VGA_ROM_ARB_OUTREG_EN defined: extra register stage on *_rvalid/*_rdata; latency 3 cycles, same ordering.
// - Undefined: latency 2 cycles as above. Reset values identical in both builds.
// STRUCTURE
// - Package vga_rom_pkg: typedef owner_t (OWN_NONE, OWN_PIX, OWN_AUX); localparams ROM_RD_LAT=1,
//   ARB_LAT_BASE=2 used by bench and timing generator to pre-advance pix_addr.
// - Sub-module rom_arb_tag_pipe: parameterised-depth owner_t shift register with async reset.
// - ROM instance stays outside; bench connects a $readmemh-loaded model holding rom[i]=i^8'hA5.
// TESTING
// - Reset: hold rst_n=0 with pix_req=1 -> all outputs 0, no rvalid for 3 cycles after release except new reqs.
// - Pixel stream: pix_req=1, addr 0..15 consecutive -> pix_rvalid each cycle from t+2, rdata=addr^8'hA5, in order.
// - Contention: pix_req=1 and aux_req=1 addr 8'h40 for 5 cycles, then pix_req=0 -> aux_gnt first in cycle 6,
//   aux_rvalid 2 cycles later, aux_rdata=8'hE5.
// - Interleave: pix on even cycles, aux held -> aux granted on odd cycles, rvalids alternate, no overlap.
// - Starvation: STARVE_LIMIT=4, pix_req=1 continuous, aux_req=1 -> aux_starve=1 after 4 cycles, clears
//   the cycle after aux_gnt.
// - Reset mid-flight: assert rst_n=0 one cycle after aux_gnt -> aux_rvalid never asserts for that request.

Source files
------------

// File: rtl/vga_rom_pkg.sv
// Shared types and constants for the VGA image ROM arbiter.
//
// owner_t encodes the {valid, is_aux} tag that travels alongside each ROM
// access so that the returning read data can be steered to the right port.
// ARB_LAT_BASE is the pixel request -> pix_rvalid latency of the default
// build.  The timing generator uses it to pre-advance pix_addr.
// ARB_LAT is the latency of the build actually compiled.  It is one cycle
// longer when VGA_ROM_ARB_OUTREG_EN is defined.
package vga_rom_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_PIX  = 2'b10,
        OWN_AUX  = 2'b11
    } owner_t;

    localparam int ROM_RD_LAT   = 1;
    localparam int ARB_LAT_BASE = 2;
`ifdef VGA_ROM_ARB_OUTREG_EN
    localparam int ARB_LAT      = ARB_LAT_BASE + 1;
`else
    localparam int ARB_LAT      = ARB_LAT_BASE;
`endif

    // The pixel port has absolute priority.  An aux grant can therefore only
    // appear when no pixel request is present.
    function automatic owner_t pick_owner(input logic pix_req, input logic aux_gnt);
        owner_t own;
        own = OWN_NONE;
        if (pix_req) begin
            own = OWN_PIX;
        end else if (aux_gnt) begin
            own = OWN_AUX;
        end
        return own;
    endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Owner-tag delay line.
//
// This is a DEPTH-stage shift register of owner_t.  It runs in step with the
// ROM address register and the ROM's registered read.
// Reset is asynchronous and active-low.  It flushes every stage to OWN_NONE,
// so accesses that were in flight before the reset never produce an rvalid.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   tag_in  in   owner of the access granted this cycle
//   tag_out out  owner of the access whose ROM data is on rom_q now
module rom_arb_tag_pipe
    import vga_rom_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stage_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg[gi] <= OWN_NONE;
                end else if (gi == 0) begin
                    stage_reg[gi] <= tag_in;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_rom_arbiter.sv
// VGA image ROM arbiter.
//
// This block shares one synchronous single-port ROM between two requesters:
//   - The pixel scan fetch.  It has absolute priority, a fixed latency and
//     no back-pressure.
//   - An aux requester (sprite/overlay/debug).  It uses a req/gnt handshake
//     and is served only in cycles without a pixel request.
// The block owns the registered ROM address bus.
//
// Optional build macro: VGA_ROM_ARB_OUTREG_EN
//   Adds one register stage on *_rvalid / *_rdata.  Latency becomes 3 cycles
//   instead of 2, and the ordering is unchanged.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pix_req, pix_addr          pixel fetch request and address
//   pix_rvalid, pix_rdata      pixel read return
//   aux_req, aux_addr          aux request.  Held stable until aux_gnt.
//   aux_gnt                    combinational grant.  The request is consumed
//                              this cycle.
//   aux_rvalid, aux_rdata      aux read return
//   aux_starve                 aux has waited >= STARVE_LIMIT cycles.  Sticky
//                              until the next grant.
//   rom_addr                   registered ROM address
//   rom_q                      ROM read data, valid one cycle after rom_addr
module vga_rom_arbiter
    import vga_rom_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_req,
    input  logic [ADDR_WIDTH-1:0] pix_addr,
    output logic                  pix_rvalid,
    output logic [DATA_WIDTH-1:0] pix_rdata,
    input  logic                  aux_req,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    output logic                  aux_gnt,
    output logic                  aux_rvalid,
    output logic [DATA_WIDTH-1:0] aux_rdata,
    output logic                  aux_starve,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] rom_addr_reg;
    logic [CNT_WIDTH-1:0]  wait_cnt_reg;
    logic                  aux_starve_reg;
    owner_t                tag_in;
    owner_t                tag_out;

    // Index 0 is the pixel port and index 1 is the aux port.
    logic [1:0]            hit;
    logic [1:0]            rvalid_out;
    logic [DATA_WIDTH-1:0] rdata_out  [2];
    logic [DATA_WIDTH-1:0] rdata_reg  [2];

    assign aux_gnt = aux_req & ~pix_req;
    assign tag_in  = pick_owner(pix_req, aux_gnt);

    // The address register holds its value when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg <= '0;
        end else if (pix_req) begin
            rom_addr_reg <= pix_addr;
        end else if (aux_gnt) begin
            rom_addr_reg <= aux_addr;
        end
    end

    // The tag pipe is two stages deep: one for the address register and one
    // for the ROM's registered read.
    rom_arb_tag_pipe #(
        .DEPTH (1 + ROM_RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Aux wait counter and starvation flag.
    // The flag sets on the same edge at which the counter reaches the limit.
    // It stays set even if aux_req drops, and it clears only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg   <= '0;
            aux_starve_reg <= 1'b0;
        end else begin
            if (!aux_req || aux_gnt) begin
                wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != LIMIT) begin
                wait_cnt_reg <= wait_cnt_reg + CNT_WIDTH'(1);
            end

            if (aux_gnt) begin
                aux_starve_reg <= 1'b0;
            end else if (aux_req && (wait_cnt_reg >= LIMIT - CNT_WIDTH'(1))) begin
                aux_starve_reg <= 1'b1;
            end
        end
    end

    assign hit[0] = (tag_out == OWN_PIX);
    assign hit[1] = (tag_out == OWN_AUX);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
`ifdef VGA_ROM_ARB_OUTREG_EN
            logic rvalid_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg    <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    rvalid_reg <= hit[gi];
                    if (hit[gi]) begin
                        rdata_reg[gi] <= rom_q;
                    end
                end
            end
            assign rvalid_out[gi] = rvalid_reg;
            assign rdata_out[gi]  = rdata_reg[gi];
`else
            // In the base build, the return is presented in the same cycle
            // that rom_q is valid.  rdata_reg keeps the last delivered word,
            // so *_rdata holds its value between returns.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi] <= '0;
                end else if (hit[gi]) begin
                    rdata_reg[gi] <= rom_q;
                end
            end
            assign rvalid_out[gi] = hit[gi];
            assign rdata_out[gi]  = hit[gi] ? rom_q : rdata_reg[gi];
`endif
        end
    endgenerate

    assign pix_rvalid = rvalid_out[0];
    assign pix_rdata  = rdata_out[0];
    assign aux_rvalid = rvalid_out[1];
    assign aux_rdata  = rdata_out[1];
    assign aux_starve = aux_starve_reg;
    assign rom_addr   = rom_addr_reg;

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// Directed testbench for vga_rom_arbiter.
//
// The ROM model holds rom[i] = i ^ 8'hA5 and uses a registered read.
// Inputs change on the falling edge.  Outputs are sampled 1 ns later, so
// each sample shows the registered state of the current cycle together with
// the combinational response to this cycle's inputs.
module tb_vga_rom_arbiter;

`ifdef VGA_ROM_ARB_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_req;
    logic [7:0] pix_addr;
    logic       pix_rvalid;
    logic [7:0] pix_rdata;
    logic       aux_req;
    logic [7:0] aux_addr;
    logic       aux_gnt;
    logic       aux_rvalid;
    logic [7:0] aux_rdata;
    logic       aux_starve;
    logic [7:0] rom_addr;
    logic [7:0] rom_q;
    logic [7:0] rom_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_rom_arbiter #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (8),
        .STARVE_LIMIT (4),
        .CNT_WIDTH    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_req    (pix_req),
        .pix_addr   (pix_addr),
        .pix_rvalid (pix_rvalid),
        .pix_rdata  (pix_rdata),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_gnt    (aux_gnt),
        .aux_rvalid (aux_rvalid),
        .aux_rdata  (aux_rdata),
        .aux_starve (aux_starve),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q)
    );

    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic drive(input logic pr, input logic [7:0] pa, input logic ar, input logic [7:0] aa);
        @(negedge clk);
        pix_req  = pr;
        pix_addr = pa;
        aux_req  = ar;
        aux_addr = aa;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        logic ev;
        int   j;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
        rom_q = 8'h00;

        // Reset held while pix_req is active.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h33, 1'b1, 8'h44);
            $display("reset cyc %0d: rom_addr=%0h pv=%0b av=%0b", k, rom_addr, pix_rvalid, aux_rvalid);
        end
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_pix_rvalid", 32'(pix_rvalid), 32'h0);
        chk("rst_aux_rvalid", 32'(aux_rvalid), 32'h0);
        chk("rst_pix_rdata", 32'(pix_rdata), 32'h0);
        chk("rst_aux_rdata", 32'(aux_rdata), 32'h0);
        chk("rst_aux_starve", 32'(aux_starve), 32'h0);
        chk("rst_aux_gnt", 32'(aux_gnt), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) drive(1'b0, 8'h00, 1'b0, 8'h00);
            chk("post_rst_pix_rvalid", 32'(pix_rvalid), 32'h0);
            chk("post_rst_aux_rvalid", 32'(aux_rvalid), 32'h0);
        end

        // Pixel stream: addresses 0..15 on consecutive cycles.
        for (int k = 0; k < 16 + LAT + 1; k++) begin
            if (k < 16) drive(1'b1, 8'(k), 1'b0, 8'h00);
            else        drive(1'b0, 8'hFF, 1'b0, 8'h00);
            ev = (k >= LAT) && (k < 16 + LAT);
            $display("pixel cyc %0d: pv=%0b pd=%0h", k, pix_rvalid, pix_rdata);
            chk("pix_stream_rvalid", 32'(pix_rvalid), 32'(ev));
            if (ev) chk("pix_stream_rdata", 32'(pix_rdata), 32'(8'(k - LAT) ^ 8'hA5));
            chk("pix_stream_aux_rvalid", 32'(aux_rvalid), 32'h0);
        end
        chk("hold_rom_addr", 32'(rom_addr), 32'h0F);
        chk("hold_pix_rdata", 32'(pix_rdata), 32'hAA);

        // Contention: aux waits five cycles behind the pixel port.
        for (int k = 0; k < 5 + LAT + 2; k++) begin
            if (k < 5)       drive(1'b1, 8'(8'h10 + k), 1'b1, 8'h40);
            else if (k == 5) drive(1'b0, 8'h00, 1'b1, 8'h40);
            else             drive(1'b0, 8'h00, 1'b0, 8'h00);
            $display("contend cyc %0d: gnt=%0b pv=%0b av=%0b ad=%0h", k, aux_gnt, pix_rvalid, aux_rvalid, aux_rdata);
            if (k <= 5) chk("contend_gnt", 32'(aux_gnt), 32'(k == 5));
            chk("contend_pix_rvalid", 32'(pix_rvalid), 32'((k >= LAT) && (k < 5 + LAT)));
            chk("contend_aux_rvalid", 32'(aux_rvalid), 32'(k == 5 + LAT));
            if (k == 5 + LAT) chk("contend_aux_rdata", 32'(aux_rdata), 32'hE5);
        end
        chk("contend_aux_rdata_hold", 32'(aux_rdata), 32'hE5);

        // Starvation with STARVE_LIMIT = 4.
        idle(2);
        for (int k = 0; k < 8; k++) begin
            if (k < 6)       drive(1'b1, 8'h01, 1'b1, 8'h02);
            else if (k == 6) drive(1'b0, 8'h00, 1'b1, 8'h02);
            else             drive(1'b0, 8'h00, 1'b0, 8'h00);
            $display("starve cyc %0d: gnt=%0b starve=%0b", k, aux_gnt, aux_starve);
            chk("starve_flag", 32'(aux_starve), 32'((k >= 4) && (k <= 6)));
            if (k == 6) chk("starve_gnt", 32'(aux_gnt), 32'h1);
        end

        // Interleave: pixel requests on even cycles, aux request held.
        idle(4);
        for (int k = 0; k < 8 + LAT + 1; k++) begin
            if (k < 8) drive((k % 2) == 0, 8'(8'h20 + k), 1'b1, 8'h41);
            else       drive(1'b0, 8'h00, 1'b0, 8'h00);
            j  = k - LAT;
            ev = (j >= 0) && (j < 8);
            $display("ilv cyc %0d: gnt=%0b pv=%0b pd=%0h av=%0b ad=%0h", k, aux_gnt, pix_rvalid, pix_rdata, aux_rvalid, aux_rdata);
            if (k < 8) chk("ilv_gnt", 32'(aux_gnt), 32'((k % 2) == 1));
            chk("ilv_pix_rvalid", 32'(pix_rvalid), 32'(ev && (j % 2 == 0)));
            chk("ilv_aux_rvalid", 32'(aux_rvalid), 32'(ev && (j % 2 == 1)));
            if (ev && (j % 2 == 0)) chk("ilv_pix_rdata", 32'(pix_rdata), 32'(8'(8'h20 + j) ^ 8'hA5));
            if (ev && (j % 2 == 1)) chk("ilv_aux_rdata", 32'(aux_rdata), 32'hE4);
        end

        // Reset one cycle after an aux grant: that request never returns.
        idle(3);
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        chk("midrst_gnt", 32'(aux_gnt), 32'h1);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midrst_aux_rdata", 32'(aux_rdata), 32'h0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) drive(1'b0, 8'h00, 1'b0, 8'h00);
            $display("midrst cyc %0d: av=%0b ad=%0h", k, aux_rvalid, aux_rdata);
            chk("midrst_aux_rvalid", 32'(aux_rvalid), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
